// File: rtl/aes_uart_pkg.sv
// Shared types and constants for the AES-256 UART byte sequencer.
// FSM state encoding, command bytes, frame sizes and byte-lane position helpers.
package aes_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEY,
    ST_DATA,
    ST_START,
    ST_WAIT_SKIP,
    ST_WAIT,
    ST_SEND
  } state_e;

  localparam logic [7:0] CMD_KEY_DEF  = 8'h4B;
  localparam logic [7:0] CMD_DATA_DEF = 8'h44;
  localparam logic [7:0] ERR_BYTE     = 8'hEE;
  localparam int         KEY_BYTES    = 32;
  localparam int         BLK_BYTES    = 16;

  // Bytes are MSB-first: byte n of a frame lands at bit offset 8*(N-1-n).
  function automatic logic [7:0] key_lsb(input logic [4:0] idx);
    return {~idx, 3'b000};
  endfunction

  function automatic logic [6:0] blk_lsb(input logic [3:0] idx);
    return {~idx, 3'b000};
  endfunction

endpackage

// File: rtl/aes_tx_shifter.sv
// 128-bit load/shift register that streams its top byte over a valid/ready link.
// load_len_i selects how many bytes go out (16 for a ciphertext, 1 for the error byte).
module aes_tx_shifter
  import aes_uart_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [127:0] load_data_i,
  input  logic [4:0]   load_len_i,
  input  logic         tx_ready_i,
  output logic [7:0]   tx_data_o,
  output logic         tx_valid_o,
  output logic         done_o
);

  logic [127:0] shreg_q, shreg_d;
  logic [4:0]   cnt_q, cnt_d;
  logic [4:0]   len_q, len_d;
  logic         valid_q, valid_d;
  logic         accept;

  assign accept     = valid_q && tx_ready_i;
  assign done_o     = accept && (cnt_q == (len_q - 5'd1));
  assign tx_data_o  = shreg_q[127:120];
  assign tx_valid_o = valid_q;

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    valid_d = valid_q;
    if (load_i) begin
      shreg_d = load_data_i;
      cnt_d   = 5'd0;
      len_d   = load_len_i;
      valid_d = 1'b1;
    end else if (accept) begin
      shreg_d = {shreg_q[119:0], 8'h00};
      // The count parks on the last byte instead of wrapping.
      if (done_o) begin
        valid_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/aes256_uart_ctrl.sv
// Byte-stream sequencer between the UART byte ports and the aes256_enc core.
// Optional core watchdog with 8'hEE error byte: define AES_UART_CTRL_TIMEOUT_EN.
//
// state        | meaning
// IDLE         | waiting for a command byte, other bytes ignored
// KEY          | collecting 32 key bytes
// DATA         | collecting 16 plaintext bytes
// START        | one-cycle core start pulse
// WAIT_SKIP    | one cycle where a stale core_ready is ignored
// WAIT         | waiting for core_ready (or watchdog expiry)
// SEND         | streaming result bytes to TX
module aes256_uart_ctrl
  import aes_uart_pkg::*;
#(
  parameter logic [7:0] CMD_KEY     = CMD_KEY_DEF,
  parameter logic [7:0] CMD_DATA    = CMD_DATA_DEF,
  parameter int         TIMEOUT_CYC = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         core_start,
  output logic [255:0] core_key,
  output logic [127:0] core_data,
  input  logic [127:0] core_result,
  input  logic         core_ready,
  output logic         busy
);

  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 2");
  end

  state_e       state_q, state_d;
  logic [4:0]   cnt_q, cnt_d;
  logic [255:0] key_q, key_d;
  logic [127:0] data_q, data_d;

  logic         sh_load;
  logic [127:0] sh_load_data;
  logic [4:0]   sh_load_len;
  logic         sh_done;

`ifdef AES_UART_CTRL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            wdog_hit;

  assign wdog_hit = (wdog_q == WD_W'(TIMEOUT_CYC - 1));
`endif

  assign core_start = (state_q == ST_START);
  assign busy       = (state_q != ST_IDLE);
  assign core_key   = key_q;
  assign core_data  = data_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    key_d        = key_q;
    data_d       = data_q;
    sh_load      = 1'b0;
    sh_load_data = '0;
    sh_load_len  = '0;
`ifdef AES_UART_CTRL_TIMEOUT_EN
    wdog_d       = wdog_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          if (rx_data == CMD_KEY) begin
            state_d = ST_KEY;
            cnt_d   = 5'd0;
          end else if (rx_data == CMD_DATA) begin
            state_d = ST_DATA;
            cnt_d   = 5'd0;
          end
        end
      end
      ST_KEY: begin
        if (rx_valid) begin
          key_d[key_lsb(cnt_q) +: 8] = rx_data;
          if (cnt_q == 5'(KEY_BYTES - 1)) begin
            state_d = ST_IDLE;
            cnt_d   = 5'd0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      ST_DATA: begin
        if (rx_valid) begin
          data_d[blk_lsb(cnt_q[3:0]) +: 8] = rx_data;
          if (cnt_q == 5'(BLK_BYTES - 1)) begin
            state_d = ST_START;
            cnt_d   = 5'd0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      ST_START: begin
        state_d = ST_WAIT_SKIP;
`ifdef AES_UART_CTRL_TIMEOUT_EN
        wdog_d  = '0;
`endif
      end
      ST_WAIT_SKIP: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A real result wins over a watchdog expiry in the same cycle.
        if (core_ready) begin
          sh_load      = 1'b1;
          sh_load_data = core_result;
          sh_load_len  = 5'(BLK_BYTES);
          cnt_d        = 5'd0;
          state_d      = ST_SEND;
        end
`ifdef AES_UART_CTRL_TIMEOUT_EN
        else if (wdog_hit) begin
          sh_load      = 1'b1;
          sh_load_data = {ERR_BYTE, 120'h0};
          sh_load_len  = 5'd1;
          cnt_d        = 5'd0;
          state_d      = ST_SEND;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
`endif
      end
      ST_SEND: begin
        if (sh_done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      key_q   <= '0;
      data_q  <= '0;
`ifdef AES_UART_CTRL_TIMEOUT_EN
      wdog_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      data_q  <= data_d;
`ifdef AES_UART_CTRL_TIMEOUT_EN
      wdog_q  <= wdog_d;
`endif
    end
  end

  aes_tx_shifter u_tx_shifter (
    .clk         (clk),
    .reset       (reset),
    .load_i      (sh_load),
    .load_data_i (sh_load_data),
    .load_len_i  (sh_load_len),
    .tx_ready_i  (tx_ready),
    .tx_data_o   (tx_data),
    .tx_valid_o  (tx_valid),
    .done_o      (sh_done)
  );

endmodule

// File: tb/tb_aes256_uart_ctrl.sv
// Self-checking bench for aes256_uart_ctrl: random frames against a frame-level model
// with a behavioural core stand-in and a TX byte scoreboard.
`timescale 1ns/1ps
module tb_aes256_uart_ctrl;

  localparam int TO_CYC = 16;
  localparam logic [255:0] FIPS_KEY =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_valid = 1'b0;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready = 1'b0;
  logic         core_start;
  logic [255:0] core_key;
  logic [127:0] core_data;
  logic [127:0] core_result = '0;
  logic         core_ready = 1'b1;
  logic         busy;

  always #5 clk = ~clk;

  aes256_uart_ctrl #(.TIMEOUT_CYC(TO_CYC)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .core_start  (core_start),
    .core_key    (core_key),
    .core_data   (core_data),
    .core_result (core_result),
    .core_ready  (core_ready),
    .busy        (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stand-in for the cipher: the real vector for FIPS-197 C.3, otherwise a keyed mix.
  function automatic logic [127:0] enc_ref(input logic [255:0] k, input logic [127:0] d);
    if (k == FIPS_KEY && d == FIPS_PT) return FIPS_CT;
    return k[255:128] ^ {k[119:0], k[127:120]} ^ d ^ 128'h5a5a_c3c3_0f0f_9696_a5a5_3c3c_f0f0_6969;
  endfunction

  // Core model, TX monitor and scoreboard share one negedge process for a fixed order.
  int           cyc = 0;
  int           core_phase = 0;
  int           core_lat_cnt = 0;
  int           core_lat = 3;
  bit           core_hang = 1'b0;
  int           n_starts = 0;
  logic [255:0] st_key = '0;
  logic [127:0] st_data = '0;
  int           raise_cyc = 0;
  bit           want_first = 1'b0;
  logic [7:0]   exp_q[$];
  int           frame_left = 0;
  bit           idle_chk = 1'b0;
  bit           hold_prev = 1'b0;
  logic [7:0]   prev_data = 8'h00;
  int           n_extra = 0;
  bit           ready_force_low = 1'b0;

  always @(negedge clk) begin
    logic [7:0] e;
    cyc++;
    if (reset) begin
      core_phase = 0;
      core_ready = 1'b1;
      hold_prev  = 1'b0;
      idle_chk   = 1'b0;
      want_first = 1'b0;
    end else begin
      if (idle_chk) begin
        chk("busy_after_last", 256'(busy), 256'(0));
        chk("tx_valid_after_last", 256'(tx_valid), 256'(0));
        idle_chk = 1'b0;
      end
      if (hold_prev) begin
        chk("tx_hold_valid", 256'(tx_valid), 256'(1));
        chk("tx_hold_data", 256'(tx_data), 256'(prev_data));
      end
      if (want_first && tx_valid) begin
        chk("ready_to_tx_latency", 256'(cyc), 256'(raise_cyc + 1));
        want_first = 1'b0;
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          n_extra++;
        end else begin
          e = exp_q.pop_front();
          chk("tx_byte", 256'(tx_data), 256'(e));
          frame_left--;
          if (frame_left == 0) idle_chk = 1'b1;
        end
      end
      hold_prev = tx_valid && !tx_ready;
      prev_data = tx_data;

      if (core_start) n_starts++;
      case (core_phase)
        0: if (core_start) begin
          st_key     = core_key;
          st_data    = core_data;
          core_phase = 1;
        end
        1: core_phase = 2;               // ready still high here: a stale ready
        2: begin
          core_ready   = 1'b0;
          core_lat_cnt = core_lat;
          core_phase   = 3;
        end
        default: if (!core_hang) begin
          if (core_lat_cnt == 0) begin
            chk("core_key_hold", core_key, st_key);
            chk("core_data_hold", 256'(core_data), 256'(st_data));
            core_result = enc_ref(core_key, core_data);
            core_ready  = 1'b1;
            raise_cyc   = cyc;
            want_first  = 1'b1;
            core_phase  = 0;
          end else begin
            core_lat_cnt--;
          end
        end
      endcase
    end
  end

  always @(posedge clk) begin
    #1;
    if (ready_force_low) tx_ready = 1'b0;
    else tx_ready = ($urandom_range(0, 99) < 70);
  end

  logic [255:0] m_key = '0;

  task automatic rx_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_key(input logic [255:0] k);
    rx_byte(8'h4B, $urandom_range(0, 2));
    for (int i = 0; i < 32; i++) rx_byte(k[255-8*i -: 8], $urandom_range(0, 2));
    m_key = k;
  endtask

  task automatic send_data(input logic [127:0] d, input bit expect_err);
    logic [127:0] ct;
    rx_byte(8'h44, $urandom_range(0, 2));
    for (int i = 0; i < 15; i++) rx_byte(d[127-8*i -: 8], $urandom_range(0, 2));
    rx_byte(d[7:0], 0);
    chk("start_latency", 256'(core_start), 256'(1));
    if (expect_err) begin
      exp_q.push_back(8'hEE);
      frame_left += 1;
    end else begin
      ct = enc_ref(m_key, d);
      for (int i = 0; i < 16; i++) exp_q.push_back(ct[127-8*i -: 8]);
      frame_left += 16;
    end
  endtask

  task automatic wait_tx_done(input int s0);
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    chk("tx_done_in_time", 256'(t < 3000), 256'(1));
    chk("start_count", 256'(n_starts - s0), 256'(1));
    @(posedge clk); #1;
  endtask

  task automatic check_quiet(input string pfx);
    chk({pfx, "_busy"}, 256'(busy), 256'(0));
    chk({pfx, "_tx_valid"}, 256'(tx_valid), 256'(0));
    chk({pfx, "_tx_data"}, 256'(tx_data), 256'(0));
    chk({pfx, "_core_start"}, 256'(core_start), 256'(0));
    chk({pfx, "_core_key"}, core_key, 256'(0));
    chk({pfx, "_core_data"}, 256'(core_data), 256'(0));
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r = '0;
    for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom)};
    return r;
  endfunction

  initial begin
    int s0;
    int t;
    logic [255:0] rk;
    logic [127:0] rd;

    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    reset = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // FIPS-197 C.3 vector
    send_key(FIPS_KEY);
    s0 = n_starts;
    send_data(FIPS_PT, 1'b0);
    wait_tx_done(s0);

    // stray byte in IDLE, retained key
    rx_byte(8'h7A, 1);
    rd = rand256()[127:0];
    s0 = n_starts;
    send_data(rd, 1'b0);
    wait_tx_done(s0);

    // tx_ready held low mid-SEND
    rd = rand256()[127:0];
    s0 = n_starts;
    send_data(rd, 1'b0);
    t = 0;
    while (frame_left > 9 && t < 1000) begin @(posedge clk); #1; t++; end
    ready_force_low = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    ready_force_low = 1'b0;
    wait_tx_done(s0);

    // bytes arriving in START/WAIT_SKIP/WAIT and SEND are dropped
    core_lat = 12;
    rd = rand256()[127:0];
    s0 = n_starts;
    send_data(rd, 1'b0);
    rx_byte(8'h44, 1);
    rx_byte(8'h4B, 1);
    rx_byte(8'h3C, 0);
    t = 0;
    while (!tx_valid && t < 200) begin @(posedge clk); #1; t++; end
    rx_byte(8'h44, 0);
    rx_byte(8'h4B, 0);
    rx_byte(8'h7A, 0);
    wait_tx_done(s0);
    core_lat = 3;
    rd = rand256()[127:0];
    s0 = n_starts;
    send_data(rd, 1'b0);
    wait_tx_done(s0);

    // randomized key/data frames
    for (int f = 0; f < 4; f++) begin
      core_lat = $urandom_range(0, 8);
      if ($urandom_range(0, 1) == 1 || f == 0) begin
        rk = rand256();
        send_key(rk);
      end
      rd = rand256()[127:0];
      s0 = n_starts;
      send_data(rd, 1'b0);
      wait_tx_done(s0);
    end

    // reset during key byte 20
    rx_byte(8'h4B, 0);
    rk = rand256();
    for (int i = 0; i < 20; i++) rx_byte(rk[255-8*i -: 8], $urandom_range(0, 1));
    reset = 1'b1;
    @(posedge clk); #1;
    check_quiet("midreset");
    reset = 1'b0;
    m_key = '0;
    @(posedge clk); #1;
    rd = rand256()[127:0];
    s0 = n_starts;
    send_data(rd, 1'b0);
    wait_tx_done(s0);

`ifdef AES_UART_CTRL_TIMEOUT_EN
    core_hang = 1'b1;
    rd = rand256()[127:0];
    s0 = n_starts;
    send_data(rd, 1'b1);
    wait_tx_done(s0);
    core_hang = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    chk("late_ready_busy", 256'(busy), 256'(0));
    chk("late_ready_tx_valid", 256'(tx_valid), 256'(0));
`endif

    repeat (5) begin @(posedge clk); #1; end
    chk("tx_extra_bytes", 256'(n_extra), 256'(0));
    chk("tx_missing_bytes", 256'(exp_q.size()), 256'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/aes256_uart_ctrl.md
Name: aes256_uart_ctrl

Overview:
Byte-stream sequencer between the UART byte interfaces and the aes256_enc core.
- Parses command frames from RX and assembles the 256-bit key and 128-bit plaintext.
- Pulses the core start, waits for completion, latches the ciphertext and streams it to TX with a valid/ready handshake.
- Sits at the top level between uart_rx/uart_tx and aes256_enc.

Parameters:
CMD_KEY, 8'h4B, command byte announcing 32 key bytes
CMD_DATA, 8'h44, command byte announcing 16 plaintext bytes; triggers encryption
TIMEOUT_CYC, 1024, watchdog limit in clk cycles (used only with the optional feature)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe, rx_data valid; no backpressure
tx_data  out  8  byte to transmit
tx_valid  out  1  tx_data valid, held until accepted
tx_ready  in  1  transmitter accepts byte when tx_valid&&tx_ready
core_start  out  1  one-cycle start pulse to aes256_enc
core_key  out  256  key to core
core_data  out  128  plaintext to core
core_result  in  128  ciphertext from core
core_ready  in  1  core result valid / core idle
busy  out  1  high in every state except IDLE

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-high, sampled on the rising clk edge.
- Reset values: all outputs 0; key register 0; data register 0; state IDLE; all counters 0.
- Reset mid-operation: abandons the current frame and any pending TX byte next cycle. The key register is cleared.
- Byte order is MSB-first:
  - Key byte n (0..31) writes core_key[255-8n -: 8].
  - Data byte n (0..15) writes core_data[127-8n -: 8].
  - Ciphertext byte n is core_result[127-8n -: 8] of the latched result.
- States:
  - IDLE:
    - rx_valid && rx_data==CMD_KEY -> KEY, cnt=0.
    - rx_valid && rx_data==CMD_DATA -> DATA, cnt=0.
    - Any other byte is ignored.
  - KEY: each rx_valid stores a byte and cnt++. The byte with cnt==31 -> IDLE. The key is retained until reset or the next KEY frame.
  - DATA: each rx_valid stores a byte. The byte with cnt==15 -> START.
  - START: core_start=1 for exactly one cycle -> WAIT_SKIP.
  - WAIT_SKIP: one cycle, core_ready ignored so a stale ready is never sampled -> WAIT.
  - WAIT: on core_ready==1, latch core_result into the 128-bit TX shift register, cnt=0 -> SEND.
  - SEND:
    - tx_valid=1 and tx_data=current byte.
    - On tx_valid&&tx_ready: shift left 8 and cnt++.
    - Accepting the byte with cnt==15 -> IDLE, tx_valid=0 in the next cycle.
- tx_data stays stable while tx_valid&&!tx_ready.
- RX bytes arriving in START/WAIT_SKIP/WAIT/SEND are dropped silently. A command byte is never recognised mid-frame.
- core_key and core_data must be held stable from START until the state leaves WAIT. They are updated only in KEY/DATA.
- A DATA frame with no prior KEY frame encrypts with the all-zero key.
- Latency:
  - Last plaintext byte to core_start: 1 cycle.
  - core_ready to first tx_valid: 1 cycle.
- Counters: cnt is 5 bits and never wraps past its terminal count.

Optional Feature:
AES_UART_CTRL_TIMEOUT_EN
- When defined: a watchdog counter clears on entry to WAIT_SKIP and increments each cycle in WAIT.
- If it reaches TIMEOUT_CYC-1 without core_ready, the block sends the single byte 8'hEE via SEND rules, then returns to IDLE.
- A core_ready arriving after the timeout is ignored.
- When undefined: no watchdog logic is present, and WAIT can last indefinitely.

Decomposition:
- Shared package aes_uart_pkg holds:
  - state enum (IDLE, KEY, DATA, START, WAIT_SKIP, WAIT, SEND)
  - CMD_KEY/CMD_DATA defaults
  - ERR_BYTE=8'hEE
  - KEY_BYTES=32, BLK_BYTES=16
- One sub-module is natural: aes_tx_shifter. It is a 128-bit load/shift register with byte counter and valid/ready handshake. It is reused for the error byte (load count 1).

Test Plan:
- Reset then rx 4B,00..1F, then 44,00,11,22..FF (FIPS-197 C.3 key/plaintext); core model returns 8EA2B7CA516745BFEAFC49904B496089 -> core_start pulses once; TX emits 8E,A2,..,89 in order; busy falls after the 16th accept.
- Byte 7A in IDLE, then 44+16 bytes -> 7A ignored; encryption runs with the retained key.
- tx_ready held low 10 cycles mid-SEND -> tx_data/tx_valid stable throughout; no byte lost or duplicated.
- rx bytes injected during WAIT and SEND -> dropped; next IDLE 44 frame processed correctly.
- reset asserted at key byte 20 -> all outputs 0 next cycle; core_key==0; subsequent 44 frame uses the zero key.
- (AES_UART_CTRL_TIMEOUT_EN) core_ready never asserts, TIMEOUT_CYC=16 -> single tx byte EE; then IDLE; late core_ready ignored.
